// File: rtl/power_spectrum.sv
`default_nettype none
// ============================================================================
//  Module      : power_spectrum
//  Description : Turns a natural-order complex FFT stream into per-bin power
//                (re^2 + im^2) for bins 0..N/2. The result is logically
//                shifted right, then saturated to OUT_WIDTH bits. Three
//                register stages, no backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module power_spectrum #(
    parameter int N         = 128,
    parameter int BITS      = 7,
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        di_en,
    input  logic signed [WIDTH-1:0]     di_re,
    input  logic signed [WIDTH-1:0]     di_im,
    output logic                        do_en,
    output logic        [OUT_WIDTH-1:0] do_pow,
    output logic        [BITS-1:0]      do_bin,
    output logic                        do_sof,
    output logic                        do_eof
);

    localparam logic [BITS-1:0] c_HALF = BITS'(N / 2);
    localparam logic [BITS-1:0] c_ONE  = BITS'(1);

    // Input bin counter; N is a power of two, so the natural wrap gives N-1 -> 0
    logic [BITS-1:0]            r_cnt;

    // Stage 1: captured sample
    logic                       r_s1_vld;
    logic signed [WIDTH-1:0]    r_s1_re;
    logic signed [WIDTH-1:0]    r_s1_im;
    logic [BITS-1:0]            r_s1_bin;

    // Stage 2: squared components
    logic                       r_s2_vld;
    logic [2*WIDTH-1:0]         r_s2_rr;
    logic [2*WIDTH-1:0]         r_s2_ii;
    logic [BITS-1:0]            r_s2_bin;

    // Stage 3: output registers
    logic                       r_do_en;
    logic [OUT_WIDTH-1:0]       r_do_pow;
    logic [BITS-1:0]            r_do_bin;
    logic                       r_do_sof;
    logic                       r_do_eof;

    logic signed [2*WIDTH-1:0]  w_re_ext;
    logic signed [2*WIDTH-1:0]  w_im_ext;
    logic [2*WIDTH-1:0]         w_rr;
    logic [2*WIDTH-1:0]         w_ii;
    logic [2*WIDTH:0]           w_sum;
    logic [2*WIDTH:0]           w_shift;
    logic                       w_sat;
    logic [OUT_WIDTH-1:0]       w_pow;
    logic                       w_keep;

    // Only the non-redundant half of the spectrum (0..N/2) enters the pipe
    assign w_keep = di_en && (r_cnt <= c_HALF);

    // Advance the bin index on every accepted sample; hold during gaps
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (di_en) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // Stage 1: register the sample and its bin tag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_re  <= '0;
            r_s1_im  <= '0;
            r_s1_bin <= '0;
        end else begin
            r_s1_vld <= w_keep;
            r_s1_re  <= di_re;
            r_s1_im  <= di_im;
            r_s1_bin <= r_cnt;
        end
    end

    // A square is never negative and at most 2^(2*WIDTH-2), so 2*WIDTH
    // unsigned bits always hold it exactly
    assign w_re_ext = {{WIDTH{r_s1_re[WIDTH-1]}}, r_s1_re};
    assign w_im_ext = {{WIDTH{r_s1_im[WIDTH-1]}}, r_s1_im};
    assign w_rr     = w_re_ext * w_re_ext;
    assign w_ii     = w_im_ext * w_im_ext;

    // Stage 2: register the squares
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s2_vld <= 1'b0;
            r_s2_rr  <= '0;
            r_s2_ii  <= '0;
            r_s2_bin <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_rr  <= w_rr;
            r_s2_ii  <= w_ii;
            r_s2_bin <= r_s1_bin;
        end
    end

    // Full-precision sum (one extra bit), then logical shift and clamp
    assign w_sum   = {1'b0, r_s2_rr} + {1'b0, r_s2_ii};
    assign w_shift = w_sum >> SHIFT;
    assign w_sat   = |w_shift[2*WIDTH:OUT_WIDTH];
    assign w_pow   = w_sat ? {OUT_WIDTH{1'b1}} : w_shift[OUT_WIDTH-1:0];

    // Stage 3: outputs; sideband is zero when idle, power holds its last value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_do_en  <= 1'b0;
            r_do_pow <= '0;
            r_do_bin <= '0;
            r_do_sof <= 1'b0;
            r_do_eof <= 1'b0;
        end else begin
            r_do_en  <= r_s2_vld;
            r_do_bin <= r_s2_vld ? r_s2_bin : '0;
            r_do_sof <= r_s2_vld && (r_s2_bin == '0);
            r_do_eof <= r_s2_vld && (r_s2_bin == c_HALF);
            if (r_s2_vld) begin
                r_do_pow <= w_pow;
            end
        end
    end

    assign do_en  = r_do_en;
    assign do_pow = r_do_pow;
    assign do_bin = r_do_bin;
    assign do_sof = r_do_sof;
    assign do_eof = r_do_eof;

endmodule
`default_nettype wire

// File: doc/power_spectrum.md
POWER_SPECTRUM -- requirements
Module: power_spectrum

Interface
REQ-001 Parameter N, default 128: FFT frame size in bins; power of 2, N >= 4.
REQ-002 Parameter BITS, default 7: log2(N); width of the bin index.
REQ-003 Parameter WIDTH, default 16: width of each signed two's-complement input component.
REQ-004 Parameter OUT_WIDTH, default 32: width of the unsigned power output; range WIDTH..2*WIDTH.
REQ-005 Parameter SHIFT, default 0: right-shift applied to the power before saturation; range 0..2*WIDTH-1.
REQ-006 Port clock  input  1: single rising-edge clock for all state.
REQ-007 Port reset  input  1: synchronous, active-high reset.
REQ-008 Port di_en  input  1: input sample valid; one complex bin per asserted cycle, natural order.
REQ-009 Port di_re  input  WIDTH: real part, signed.
REQ-010 Port di_im  input  WIDTH: imaginary part, signed.
REQ-011 Port do_en  output  1: output power valid.
REQ-012 Port do_pow  output  OUT_WIDTH: unsigned power of the bin, shifted and saturated.
REQ-013 Port do_bin  output  BITS: bin index of do_pow, range 0..N/2.
REQ-014 Port do_sof  output  1: high with do_en on bin 0.
REQ-015 Port do_eof  output  1: high with do_en on bin N/2.

Function
REQ-016 The block SHALL keep an input bin counter of BITS bits that increments on every di_en cycle and wraps from N-1 to 0.
REQ-017 The input sample taken while the counter equals k SHALL be treated as bin k of the current frame.
REQ-018 Bins 0..N/2 inclusive SHALL be processed, and bins N/2+1..N-1 SHALL be consumed but SHALL never produce do_en.
REQ-019 Gaps (di_en low) SHALL be allowed anywhere, including mid-frame; the counter holds during a gap.
REQ-020 The datapath SHALL be a 3-stage pipeline: S1 registers re, im, bin and valid; S2 registers re*re and im*im as 2*WIDTH-bit unsigned values; S3 registers the outputs.
REQ-021 Latency SHALL be exactly 3 cycles from the di_en edge to the do_en edge, independent of gaps.
REQ-022 The pipeline SHALL accept one input per cycle with no backpressure.
REQ-023 The sum SHALL be computed as p = re*re + im*im at 2*WIDTH+1 bits with no intermediate truncation.
REQ-024 The worst case (-2^(WIDTH-1), -2^(WIDTH-1)) SHALL yield exactly 2^(2*WIDTH-1).
REQ-025 The output SHALL be do_pow = p >> SHIFT (logical shift).
REQ-026 If the shifted value exceeds 2^OUT_WIDTH-1, do_pow SHALL equal 2^OUT_WIDTH-1 (saturation, no wrap).
REQ-027 do_bin, do_sof and do_eof SHALL be pipelined alongside the data and be valid only when do_en=1.
REQ-028 do_sof, do_eof and do_bin SHALL be 0 whenever do_en=0.
REQ-029 do_pow SHALL hold its last value while do_en=0.
REQ-030 When N/2 is the last processed bin, do_eof SHALL assert on it even if later input bins never arrive.
REQ-031 There is no inter-frame state beyond the bin counter; back-to-back frames SHALL stream without bubbles.

Reset
REQ-032 While reset=1, the bin counter and all pipeline valid bits SHALL clear to 0.
REQ-033 While reset=1, do_en, do_sof, do_eof, do_bin and do_pow SHALL be 0.
REQ-034 Reset mid-frame SHALL discard in-flight samples (no do_en in the 3 cycles after release caused by pre-reset inputs).
REQ-035 After reset, the next di_en sample SHALL be bin 0.
REQ-036 di_en SHALL be ignored in any cycle where reset=1.

Verification (N=8, WIDTH=16, OUT_WIDTH=32, SHIFT=0 unless noted)
REQ-037 Ramp frame: 8 contiguous samples re=k, im=-k, k=0..7 -> 5 outputs, do_pow=0,2,8,18,32, do_bin=0..4, sof on bin0, eof on bin4, first do_en 3 cycles after first di_en.
REQ-038 Extremes: re=im=-32768 on bin 0 -> do_pow=0x80000000; re=32767, im=0 -> 0x3FFF0001.
REQ-039 Saturation (OUT_WIDTH=16, SHIFT=8): re=im=-32768 -> do_pow=0xFFFF; re=16, im=0 -> do_pow=1.
REQ-040 Gapped input: same frame as REQ-037 with di_en toggling 1,0,1,0... -> identical do_pow/do_bin sequence, each do_en exactly 3 cycles after its input.
REQ-041 Streaming: 3 back-to-back frames with no gaps -> 15 outputs, sof/eof per frame, bins 5..7 never output.
REQ-042 Reset mid-frame: reset for 1 cycle after input bin 2 -> no outputs from pre-reset inputs; the next sample is output as do_bin=0 with do_sof=1.
